psx_pad_host: RTL and testbench
===============================

Name: psx_pad_host

Overview:
- Console-side master for the PSX controller serial bus. It sits directly upstream of the pad.
- On each `start` pulse it drops `att` and generates `psx_clk`. It shifts out the 5-byte poll command sequence 01 42 00 00 00, LSB first, and shifts in the pad's reply. It checks the ID bytes and handshakes on `ack`.
- It presents the 16 button bits, active-low, to the rest of the design.

Parameters:
- CLK_DIV, default 4: `clk` cycles per `psx_clk` half-period (min 2).
- ATT_SETUP, default 8: `clk` cycles from `att` falling to the first `psx_clk` falling edge.
- ACK_TIMEOUT, default 64: `clk` cycles allowed for `ack` low after the last bit of bytes 0..3.
- BYTE_GAP, default 4: `clk` cycles of `psx_clk` high after `ack` seen, before the next byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to poll the pad; ignored while `busy`
- busy  out  1  high from the cycle after an accepted `start` until `done`
- done  out  1  one-cycle pulse at transaction end (success or error)
- buttons  out  16  {DATA2,DATA1}; updated only on success
- pad_id  out  8  byte 1 received (expected 8'h41)
- id_err  out  1  valid with `done`: byte1≠8'h41 or byte2≠8'h5A
- timeout_err  out  1  valid with `done`: `ack` not seen within ACK_TIMEOUT
- psx_clk  out  1  bus clock, idles high
- cmd  out  1  command bit, idles high
- att  out  1  active-low select, idles high
- data  in  1  pad data bit
- ack  in  1  active-low pad acknowledge pulse (asynchronous)

Behaviour:
- Reset values:
  - `att`, `psx_clk` and `cmd` = 1.
  - `busy`, `done`, `id_err` and `timeout_err` = 0.
  - `buttons` = 16'hFFFF and `pad_id` = 8'h00.
  - FSM goes to IDLE. Reset mid-transaction aborts immediately to these values; no `done` pulse.
- Inputs `data` and `ack` each pass through a 2-flop synchronizer. An `ack` low on the synchronized output for ≥1 cycle counts as seen.
- IDLE:
  - `start` → ATT_SETUP: `att`←0, `busy`←1, byte index←0, bit index←0, error flags cleared.
- ATT_SETUP: wait ATT_SETUP cycles → BIT_LOW.
- BIT_LOW:
  - On entry `psx_clk`←0 and `cmd`←command[byte][bit].
  - Hold CLK_DIV cycles → BIT_HIGH.
- BIT_HIGH:
  - On entry `psx_clk`←1. The synchronized `data` is shifted in LSB-first, i.e. into bit 7 of the receive shift register, shifting right.
  - Hold CLK_DIV cycles.
  - If bit index<7: bit index+1 → BIT_LOW.
  - Else the byte is stored to rx[byte] and `cmd`←1.
  - If byte<4 → ACK_WAIT; else → FINISH.
- ACK_WAIT:
  - Counter runs from 0. Ack seen → BYTE_GAP.
  - If the counter reaches ACK_TIMEOUT first: `timeout_err`←1 → FINISH.
  - An ack already asserted when entering ACK_WAIT counts as seen.
- BYTE_GAP: wait BYTE_GAP cycles; byte+1, bit index←0 → BIT_LOW.
- FINISH:
  - `att`←1 and `psx_clk`=1.
  - `pad_id`←rx[1] if reached.
  - `id_err`←(rx[1]≠8'h41 || rx[2]≠8'h5A); skipped on timeout.
  - If no error, `buttons`←{rx[4],rx[3]}.
  - `done`←1 for one cycle, `busy`←0 → IDLE. `start` in that same cycle is ignored; the next `start` is accepted the following cycle.
- Byte 0 rx (reply to 8'h01) is discarded.
- Error flags hold until the next accepted `start`.
- Bit timing: each bit is exactly 2×CLK_DIV `clk` cycles. `cmd` changes only with the `psx_clk` falling edge; the pad samples `cmd` on rising. `att` never toggles while `psx_clk` is low.

Test Plan:
- Pad model replying 41 5A FE FD, `ack` ~2 cycles low after bytes 0..3, `start` pulse → `done` once, `buttons`=16'hFDFE, `pad_id`=8'h41, `id_err`=0, `timeout_err`=0. Exactly 40 `psx_clk` falling edges.
- Monitor `cmd` on each `psx_clk` rising edge over a full transaction → bytes 01 42 00 00 00 LSB-first. `att` high before the first and after the last edge.
- Pad never asserts `ack` after byte 0 → `done` with `timeout_err`=1 at ATT_SETUP+8×2×CLK_DIV+ACK_TIMEOUT(+1) cycles. `att`=1, `buttons` unchanged (16'hFFFF after reset).
- Pad replies 73 5A … (wrong ID) → `done`, `id_err`=1, `pad_id`=8'h73, `buttons` keeps previous value.
- `start` held high during `busy`, and `start` coincident with `done` → exactly one transaction each; second accepted only on a later cycle.
- `rst` asserted during byte 2 → next cycle `att`=1, `psx_clk`=1, `busy`=0, no `done`. A subsequent `start` completes normally with 16'hFDFE.

Source files
------------

// File: rtl/psx_pad_host.sv
// Console-side master for the PSX controller serial bus.
// Issues the 5-byte poll sequence 01 42 00 00 00 (LSB first), collects the
// pad reply, validates the ID bytes and presents the active-low button word.
module psx_pad_host #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned ATT_SETUP   = 8,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned BYTE_GAP    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] buttons,
  output logic [7:0]  pad_id,
  output logic        id_err,
  output logic        timeout_err,
  output logic        psx_clk,
  output logic        cmd,
  output logic        att,
  input  logic        data,
  input  logic        ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATT_SETUP,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_ACK_WAIT,
    S_BYTE_GAP,
    S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  byte_q, byte_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx1_q, rx1_d;
  logic [7:0]  rx2_q, rx2_d;
  logic [7:0]  rx3_q, rx3_d;
  logic [7:0]  rx4_q, rx4_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] buttons_q, buttons_d;
  logic [7:0]  pad_id_q, pad_id_d;
  logic        id_err_q, id_err_d;
  logic        timeout_err_q, timeout_err_d;
  logic        psx_clk_q, psx_clk_d;
  logic        cmd_q, cmd_d;
  logic        att_q, att_d;
  logic        data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic        ack_s1_q, ack_s1_d, ack_s2_q, ack_s2_d;
  logic        id_bad;

  // Poll command: byte 0 = 0x01, byte 1 = 0x42, remaining bytes 0x00.
  function automatic logic cmd_bit(input logic [2:0] b, input logic [2:0] i);
    logic [7:0] c;
    case (b)
      3'd0:    c = 8'h01;
      3'd1:    c = 8'h42;
      default: c = 8'h00;
    endcase
    return c[i];
  endfunction

  // Next-state and output computation for the transaction sequencer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    byte_d        = byte_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    rx1_d         = rx1_q;
    rx2_d         = rx2_q;
    rx3_d         = rx3_q;
    rx4_d         = rx4_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    buttons_d     = buttons_q;
    pad_id_d      = pad_id_q;
    id_err_d      = id_err_q;
    timeout_err_d = timeout_err_q;
    psx_clk_d     = psx_clk_q;
    cmd_d         = cmd_q;
    att_d         = att_q;
    data_s1_d     = data;
    data_s2_d     = data_s1_q;
    ack_s1_d      = ack;
    ack_s2_d      = ack_s1_q;
    id_bad        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // done_q high means FINISH just completed: a start in that cycle is dropped.
        if (start && !done_q) begin
          state_d       = S_ATT_SETUP;
          att_d         = 1'b0;
          busy_d        = 1'b1;
          byte_d        = '0;
          bit_d         = '0;
          cnt_d         = '0;
          id_err_d      = 1'b0;
          timeout_err_d = 1'b0;
        end
      end
      S_ATT_SETUP: begin
        if (cnt_q == 16'(ATT_SETUP - 1)) begin
          state_d   = S_BIT_LOW;
          cnt_d     = '0;
          psx_clk_d = 1'b0;
          cmd_d     = cmd_bit(byte_q, bit_q);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BIT_LOW: begin
        if (cnt_q == 16'(CLK_DIV - 1)) begin
          state_d   = S_BIT_HIGH;
          cnt_d     = '0;
          psx_clk_d = 1'b1;
          shift_d   = {data_s2_q, shift_q[7:1]};
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BIT_HIGH: begin
        if (cnt_q == 16'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (bit_q != 3'd7) begin
            state_d   = S_BIT_LOW;
            bit_d     = bit_q + 3'd1;
            psx_clk_d = 1'b0;
            cmd_d     = cmd_bit(byte_q, bit_q + 3'd1);
          end else begin
            cmd_d = 1'b1;
            case (byte_q)
              3'd1:    rx1_d = shift_q;
              3'd2:    rx2_d = shift_q;
              3'd3:    rx3_d = shift_q;
              3'd4:    rx4_d = shift_q;
              default: ;
            endcase
            state_d = (byte_q < 3'd4) ? S_ACK_WAIT : S_FINISH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACK_WAIT: begin
        if (!ack_s2_q) begin
          state_d = S_BYTE_GAP;
          cnt_d   = '0;
        end else if (cnt_q == 16'(ACK_TIMEOUT - 1)) begin
          state_d       = S_FINISH;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BYTE_GAP: begin
        if (cnt_q == 16'(BYTE_GAP - 1)) begin
          state_d   = S_BIT_LOW;
          cnt_d     = '0;
          byte_d    = byte_q + 3'd1;
          bit_d     = '0;
          psx_clk_d = 1'b0;
          cmd_d     = cmd_bit(byte_q + 3'd1, 3'd0);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_FINISH: begin
        state_d   = S_IDLE;
        att_d     = 1'b1;
        psx_clk_d = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        // A timeout during byte k's ack wait means rx[1] exists only when k >= 1.
        if (byte_q >= 3'd1) pad_id_d = rx1_q;
        if (!timeout_err_q) begin
          id_bad   = (rx1_q != 8'h41) || (rx2_q != 8'h5A);
          id_err_d = id_bad;
          if (!id_bad) buttons_d = {rx4_q, rx3_q};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and synchronizer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      byte_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      rx1_q         <= '0;
      rx2_q         <= '0;
      rx3_q         <= '0;
      rx4_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      buttons_q     <= '1;
      pad_id_q      <= '0;
      id_err_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      psx_clk_q     <= 1'b1;
      cmd_q         <= 1'b1;
      att_q         <= 1'b1;
      data_s1_q     <= 1'b1;
      data_s2_q     <= 1'b1;
      ack_s1_q      <= 1'b1;
      ack_s2_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      byte_q        <= byte_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      rx1_q         <= rx1_d;
      rx2_q         <= rx2_d;
      rx3_q         <= rx3_d;
      rx4_q         <= rx4_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      buttons_q     <= buttons_d;
      pad_id_q      <= pad_id_d;
      id_err_q      <= id_err_d;
      timeout_err_q <= timeout_err_d;
      psx_clk_q     <= psx_clk_d;
      cmd_q         <= cmd_d;
      att_q         <= att_d;
      data_s1_q     <= data_s1_d;
      data_s2_q     <= data_s2_d;
      ack_s1_q      <= ack_s1_d;
      ack_s2_q      <= ack_s2_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign buttons     = buttons_q;
  assign pad_id      = pad_id_q;
  assign id_err      = id_err_q;
  assign timeout_err = timeout_err_q;
  assign psx_clk     = psx_clk_q;
  assign cmd         = cmd_q;
  assign att         = att_q;

endmodule

// File: tb/tb_psx_pad_host.sv
// Self-checking bench for psx_pad_host with a behavioural pad on the bus.
module tb_psx_pad_host;
  localparam int unsigned CD = 4;
  localparam int unsigned AS = 8;
  localparam int unsigned AT = 64;
  localparam int unsigned BG = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        data = 1'b1;
  logic        ack = 1'b1;
  logic        busy, done, id_err, timeout_err, psx_clk, cmd, att;
  logic [15:0] buttons;
  logic [7:0]  pad_id;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  psx_pad_host #(.CLK_DIV(CD), .ATT_SETUP(AS), .ACK_TIMEOUT(AT), .BYTE_GAP(BG)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .buttons(buttons), .pad_id(pad_id), .id_err(id_err), .timeout_err(timeout_err),
    .psx_clk(psx_clk), .cmd(cmd), .att(att), .data(data), .ack(ack)
  );

  // Pad configuration (written by the test tasks) and pad observation state.
  logic [7:0] reply [0:4];
  logic [4:0] ack_en = 5'b01111;
  int         ack_dly_cfg = 6;
  logic       mon_en = 1'b0;
  int         pad_byte = 0, pad_bit = 0, fall_cnt = 0, ack_dly = 0, ack_low = 0;
  int         proto_err = 0, done_pulses = 0;
  logic [7:0] cmd_cap [0:4];
  logic       prev_clk = 1'b1, prev_att = 1'b1;

  // Reference model state: what the outputs should hold after each poll.
  logic [15:0] exp_buttons = 16'hFFFF;
  logic [7:0]  exp_pad_id = 8'h00;

  // Behavioural pad: drives data after psx_clk falls, samples cmd on rise,
  // pulses ack low for two cycles after each of bytes 0..3 when enabled.
  always @(negedge clk) begin
    if (done === 1'b1) done_pulses <= done_pulses + 1;
    if (mon_en && (att !== prev_att) && (psx_clk !== 1'b1)) proto_err <= proto_err + 1;
    if (ack_dly > 1) ack_dly <= ack_dly - 1;
    else if (ack_dly == 1) begin ack_dly <= 0; ack <= 1'b0; ack_low <= 2; end
    else if (ack_low > 1) ack_low <= ack_low - 1;
    else if (ack_low == 1) begin ack_low <= 0; ack <= 1'b1; end
    if (att !== 1'b0) begin
      pad_byte <= 0;
      pad_bit  <= 0;
      data     <= 1'b1;
    end else begin
      if (prev_clk === 1'b1 && psx_clk === 1'b0) begin
        fall_cnt <= fall_cnt + 1;
        if (pad_byte < 5) data <= reply[pad_byte][pad_bit];
      end
      if (prev_clk === 1'b0 && psx_clk === 1'b1) begin
        if (pad_byte < 5) cmd_cap[pad_byte][pad_bit] <= cmd;
        if (pad_bit == 7) begin
          pad_bit  <= 0;
          pad_byte <= pad_byte + 1;
          if (pad_byte < 4 && ack_en[pad_byte]) ack_dly <= ack_dly_cfg;
        end else begin
          pad_bit <= pad_bit + 1;
        end
      end
    end
    prev_clk <= psx_clk;
    prev_att <= att;
  end

  task automatic set_good_pad();
    reply[0] = 8'hFF; reply[1] = 8'h41; reply[2] = 8'h5A; reply[3] = 8'hFE; reply[4] = 8'hFD;
    ack_en = 5'b01111;
    ack_dly_cfg = CD + 2;
  endtask

  // Expected outcome from the protocol rules: first un-acked byte k ends the poll.
  task automatic model_txn(output bit e_to, output bit e_id, output int e_falls);
    int k;
    k = 4;
    for (int b = 3; b >= 0; b--) if (!ack_en[b]) k = b;
    e_to = (k < 4);
    e_id = !e_to && ((reply[1] != 8'h41) || (reply[2] != 8'h5A));
    if (k >= 1) exp_pad_id = reply[1];
    if (!e_to && !e_id) exp_buttons = {reply[4], reply[3]};
    e_falls = e_to ? 8 * (k + 1) : 40;
  endtask

  // Issue one start and wait (bounded) for done; cyc = edges after the start edge.
  task automatic poll(input bit hold, output int cyc, output bit ok,
                      output logic bf, output logic bd, output logic ad);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 if (!hold) start = 1'b0;
    cyc = 0; ok = 1'b0; bf = 1'bx; bd = 1'bx; ad = 1'bx;
    while (cyc < 3000) begin
      @(negedge clk);
      if (cyc == 0) bf = busy;
      if (done === 1'b1) begin ok = 1'b1; bd = busy; ad = att; break; end
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({att, psx_clk, cmd, busy, done, id_err, timeout_err} !== 7'b1110000) begin
      failures++; $display("FAIL reset_ctrl: got %b exp 1110000", {att, psx_clk, cmd, busy, done, id_err, timeout_err}); end
    checks++; if (buttons !== 16'hFFFF) begin failures++; $display("FAIL reset_buttons: got %h exp ffff", buttons); end
    checks++; if (pad_id !== 8'h00) begin failures++; $display("FAIL reset_pad_id: got %h exp 00", pad_id); end
    exp_buttons = 16'hFFFF;
    exp_pad_id = 8'h00;
    mon_en = 1'b1;
  endtask

  task automatic test_timeout();
    int cyc, f0, d0, e_falls, exp_cyc; bit ok, e_to, e_id; logic bf, bd, ad;
    set_good_pad();
    ack_en = 5'b00000;
    model_txn(e_to, e_id, e_falls);
    f0 = fall_cnt; d0 = done_pulses;
    exp_cyc = AS + 16 * CD + AT;
    poll(1'b0, cyc, ok, bf, bd, ad);
    repeat (10) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL to_done: got no done within bound, exp done"); end
    checks++; if (cyc != exp_cyc && cyc != exp_cyc + 1) begin
      failures++; $display("FAIL to_latency: got %0d exp %0d or %0d", cyc, exp_cyc, exp_cyc + 1); end
    checks++; if (timeout_err !== e_to || e_to !== 1'b1) begin failures++; $display("FAIL to_flag: got %b exp 1", timeout_err); end
    checks++; if (id_err !== 1'b0) begin failures++; $display("FAIL to_id_err: got %b exp 0", id_err); end
    checks++; if (ad !== 1'b1 || att !== 1'b1) begin failures++; $display("FAIL to_att: got %b/%b exp 1", ad, att); end
    checks++; if (buttons !== 16'hFFFF) begin failures++; $display("FAIL to_buttons: got %h exp ffff", buttons); end
    checks++; if (pad_id !== exp_pad_id) begin failures++; $display("FAIL to_pad_id: got %h exp %h", pad_id, exp_pad_id); end
    checks++; if (fall_cnt - f0 != e_falls) begin failures++; $display("FAIL to_falls: got %0d exp %0d", fall_cnt - f0, e_falls); end
    checks++; if (done_pulses - d0 != 1) begin failures++; $display("FAIL to_done_count: got %0d exp 1", done_pulses - d0); end
  endtask

  task automatic test_good_poll();
    int cyc, f0, d0, e_falls; bit ok, e_to, e_id; logic bf, bd, ad;
    logic [7:0] exp_cmd [0:4];
    exp_cmd[0] = 8'h01; exp_cmd[1] = 8'h42; exp_cmd[2] = 8'h00; exp_cmd[3] = 8'h00; exp_cmd[4] = 8'h00;
    set_good_pad();
    model_txn(e_to, e_id, e_falls);
    f0 = fall_cnt; d0 = done_pulses;
    checks++; if (att !== 1'b1) begin failures++; $display("FAIL good_att_before: got %b exp 1", att); end
    poll(1'b0, cyc, ok, bf, bd, ad);
    repeat (10) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL good_done: got no done within bound, exp done"); end
    checks++; if (bf !== 1'b1 || bd !== 1'b0) begin failures++; $display("FAIL good_busy: got start=%b done=%b exp 1/0", bf, bd); end
    checks++; if (buttons !== 16'hFDFE || buttons !== exp_buttons) begin
      failures++; $display("FAIL good_buttons: got %h exp fdfe", buttons); end
    checks++; if (pad_id !== 8'h41) begin failures++; $display("FAIL good_pad_id: got %h exp 41", pad_id); end
    checks++; if ({id_err, timeout_err} !== {e_id, e_to}) begin
      failures++; $display("FAIL good_flags: got %b%b exp 00", id_err, timeout_err); end
    checks++; if (fall_cnt - f0 != 40) begin failures++; $display("FAIL good_falls: got %0d exp 40", fall_cnt - f0); end
    checks++; if (done_pulses - d0 != 1) begin failures++; $display("FAIL good_done_count: got %0d exp 1", done_pulses - d0); end
    checks++; if (ad !== 1'b1) begin failures++; $display("FAIL good_att_after: got %b exp 1", ad); end
    for (int b = 0; b < 5; b++) begin
      checks++; if (cmd_cap[b] !== exp_cmd[b]) begin
        failures++; $display("FAIL good_cmd_byte%0d: got %h exp %h", b, cmd_cap[b], exp_cmd[b]); end
    end
    checks++; if (proto_err != 0) begin failures++; $display("FAIL good_att_while_clk_low: got %0d exp 0", proto_err); end
  endtask

  task automatic test_bad_id();
    int cyc, e_falls; bit ok, e_to, e_id; logic bf, bd, ad;
    logic [15:0] prev_buttons;
    set_good_pad();
    reply[1] = 8'h73; reply[3] = 8'h12; reply[4] = 8'h34;
    prev_buttons = exp_buttons;
    model_txn(e_to, e_id, e_falls);
    poll(1'b0, cyc, ok, bf, bd, ad);
    repeat (5) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL badid_done: got no done within bound, exp done"); end
    checks++; if (id_err !== 1'b1 || e_id !== 1'b1) begin failures++; $display("FAIL badid_flag: got %b exp 1", id_err); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL badid_timeout: got %b exp 0", timeout_err); end
    checks++; if (pad_id !== 8'h73) begin failures++; $display("FAIL badid_pad_id: got %h exp 73", pad_id); end
    checks++; if (buttons !== prev_buttons) begin failures++; $display("FAIL badid_buttons: got %h exp %h", buttons, prev_buttons); end
  endtask

  task automatic test_start_held();
    int cyc, d0, e_falls; bit ok, e_to, e_id; logic bf, bd, ad;
    set_good_pad();
    reply[3] = 8'hA5; reply[4] = 8'h3C;
    model_txn(e_to, e_id, e_falls);
    d0 = done_pulses;
    poll(1'b1, cyc, ok, bf, bd, ad);
    repeat (30) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL held_done: got no done within bound, exp done"); end
    checks++; if (done_pulses - d0 != 1 || busy !== 1'b0) begin
      failures++; $display("FAIL held_single_txn: got dones=%0d busy=%b exp 1/0", done_pulses - d0, busy); end
    checks++; if (buttons !== 16'h3CA5) begin failures++; $display("FAIL held_buttons: got %h exp 3ca5", buttons); end
  endtask

  task automatic test_start_at_done();
    int cyc, d0, n, e_falls; bit ok, e_to, e_id; logic bf, bd, ad;
    set_good_pad();
    model_txn(e_to, e_id, e_falls);
    d0 = done_pulses;
    poll(1'b0, cyc, ok, bf, bd, ad);
    start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL atdone_ignored: got busy=%b exp 0", busy); end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL atdone_next_accept: got busy=%b exp 1", busy); end
    reply[3] = 8'h0F; reply[4] = 8'hF0;
    model_txn(e_to, e_id, e_falls);
    n = 0;
    while (n < 3000 && done !== 1'b1) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    checks++; if (done_pulses - d0 != 2) begin failures++; $display("FAIL atdone_txn_count: got %0d exp 2", done_pulses - d0); end
    checks++; if (buttons !== exp_buttons) begin failures++; $display("FAIL atdone_buttons: got %h exp %h", buttons, exp_buttons); end
  endtask

  task automatic test_reset_mid();
    int n, d0, cyc, e_falls; bit ok, e_to, e_id; logic bf, bd, ad;
    set_good_pad();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    d0 = done_pulses;
    n = 0;
    while (n < 3000 && !(pad_byte == 2 && pad_bit == 3)) begin @(negedge clk); n++; end
    checks++; if (n >= 3000) begin failures++; $display("FAIL rstmid_reach_byte2: got no byte 2 within bound, exp byte 2"); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({att, psx_clk, busy, done} !== 4'b1100) begin
      failures++; $display("FAIL rstmid_ctrl: got %b exp 1100", {att, psx_clk, busy, done}); end
    checks++; if (buttons !== 16'hFFFF) begin failures++; $display("FAIL rstmid_buttons: got %h exp ffff", buttons); end
    exp_buttons = 16'hFFFF;
    exp_pad_id = 8'h00;
    repeat (200) @(negedge clk);
    checks++; if (done_pulses != d0) begin failures++; $display("FAIL rstmid_no_done: got %0d extra exp 0", done_pulses - d0); end
    model_txn(e_to, e_id, e_falls);
    poll(1'b0, cyc, ok, bf, bd, ad);
    repeat (5) @(negedge clk);
    checks++; if (!ok || buttons !== 16'hFDFE) begin
      failures++; $display("FAIL rstmid_recover: got done=%b buttons=%h exp 1/fdfe", ok, buttons); end
  endtask

  task automatic test_random();
    int cyc, f0, e_falls; bit ok, e_to, e_id; logic bf, bd, ad;
    for (int it = 0; it < 10; it++) begin
      reply[0] = 8'($urandom);
      reply[1] = ($urandom_range(0, 3) != 0) ? 8'h41 : 8'($urandom);
      reply[2] = ($urandom_range(0, 3) != 0) ? 8'h5A : 8'($urandom);
      reply[3] = 8'($urandom);
      reply[4] = 8'($urandom);
      ack_en = 5'b01111;
      if ($urandom_range(0, 3) == 0) ack_en[$urandom_range(0, 3)] = 1'b0;
      ack_dly_cfg = $urandom_range(2, 30);
      model_txn(e_to, e_id, e_falls);
      f0 = fall_cnt;
      poll(1'b0, cyc, ok, bf, bd, ad);
      repeat (5) @(negedge clk);
      checks++; if (!ok) begin failures++; $display("FAIL rand%0d_done: got no done within bound, exp done", it); end
      checks++; if ({timeout_err, id_err} !== {e_to, e_id}) begin
        failures++; $display("FAIL rand%0d_flags: got to=%b id=%b exp to=%b id=%b", it, timeout_err, id_err, e_to, e_id); end
      checks++; if (pad_id !== exp_pad_id) begin failures++; $display("FAIL rand%0d_pad_id: got %h exp %h", it, pad_id, exp_pad_id); end
      checks++; if (buttons !== exp_buttons) begin failures++; $display("FAIL rand%0d_buttons: got %h exp %h", it, buttons, exp_buttons); end
      checks++; if (fall_cnt - f0 != e_falls) begin failures++; $display("FAIL rand%0d_falls: got %0d exp %0d", it, fall_cnt - f0, e_falls); end
    end
    checks++; if (proto_err != 0) begin failures++; $display("FAIL rand_att_while_clk_low: got %0d exp 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_good_poll();
    test_bad_id();
    test_start_held();
    test_start_at_done();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
